// File: rtl/pcs_pkg.sv
// Shared PCS definitions: BER state encoding, sync header codes and default sizing.
// The status struct is the single registered view of the BER state machine.
package pcs_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_HI_BER = 2'd2
  } ber_state_t;

  // Registered FSM state plus its flag output, kept together for checker binding.
  typedef struct packed {
    ber_state_t state;
    logic       hi_ber;
  } ber_status_t;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int DEF_HDR_WIDTH     = 2;
  localparam int DEF_WINDOW_CYCLES = 40283;
  localparam int DEF_BER_THRESHOLD = 16;
  localparam int DEF_CNT_WIDTH     = 6;

endpackage

// File: rtl/ber_window_timer.sv
// Free-running window timer for the BER monitor: counts 0..WINDOW_CYCLES-1 and wraps.
// Clear wins over enable; done is high on the last cycle of each window.
module ber_window_timer
  import pcs_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int TIMER_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(WINDOW_CYCLES - 1);

  logic [TIMER_W-1:0] timer;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      timer <= '0;
    end else if (en) begin
      timer <= (timer == LAST) ? '0 : timer + TIMER_W'(1);
    end
  end

  assign done = (timer == LAST);

endmodule

// File: rtl/rx_ber_monitor.sv
// 10GBASE-R receive BER monitor: counts invalid sync headers per fixed window and
// raises hi_ber at threshold; also keeps a saturating, host-clearable error count.
module rx_ber_monitor
  import pcs_pkg::*;
#(
  parameter int HDR_WIDTH     = DEF_HDR_WIDTH,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int BER_THRESHOLD = DEF_BER_THRESHOLD,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [HDR_WIDTH-1:0] i_hdr,
  input  logic                 i_hdr_valid,
  input  logic                 i_block_lock,
  input  logic                 i_ber_count_clr,
  output logic                 o_hi_ber,
  output logic [CNT_WIDTH-1:0] o_ber_count
);

  // i_hdr_valid qualifies i_hdr for exactly one cycle. There is no ready: every
  // qualified header is consumed on the edge it is presented.

  localparam int BCNT_W = $clog2(BER_THRESHOLD + 1);
  localparam logic [BCNT_W-1:0]    HIT_AT   = BCNT_W'(BER_THRESHOLD - 1);
  localparam logic [HDR_WIDTH-1:0] HDR_DATA = HDR_WIDTH'(SYNC_DATA);
  localparam logic [HDR_WIDTH-1:0] HDR_CTRL = HDR_WIDTH'(SYNC_CTRL);

  ber_status_t          status_q;
  ber_state_t           state_d;
  logic                 hi_ber_d;
  logic [BCNT_W-1:0]    ber_cnt_q;
  logic [BCNT_W-1:0]    ber_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q;
  logic                 bad_hdr;
  logic                 hit;
  logic                 err_inc;
  logic                 timer_done;
  logic                 timer_clr;
  logic                 timer_en;

  assign bad_hdr = i_hdr_valid && (i_hdr != HDR_DATA) && (i_hdr != HDR_CTRL);
  assign hit     = bad_hdr && (ber_cnt_q == HIT_AT);
  assign err_inc = i_block_lock && bad_hdr;

  ber_window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .clk    (i_clk),
    .reset_n(i_reset_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .done   (timer_done)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      status_q  <= '{state: ST_INIT, hi_ber: 1'b0};
      ber_cnt_q <= '0;
    end else begin
      status_q  <= '{state: state_d, hi_ber: hi_ber_d};
      ber_cnt_q <= ber_cnt_d;
    end
  end

  // Lock loss overrides every other transition.
  always_comb begin
    state_d = status_q.state;
    if (!i_block_lock) begin
      state_d = ST_INIT;
    end else begin
      case (status_q.state)
        ST_INIT:   state_d = ST_COUNT;
        ST_COUNT:  if (hit && !timer_done) state_d = ST_HI_BER;
        ST_HI_BER: if (timer_done) state_d = ST_COUNT;
        default:   state_d = ST_INIT;
      endcase
    end
  end

  // A hit on the last window cycle keeps counting in a fresh window with hi_ber set;
  // hi_ber only drops when a full ST_COUNT window closes without a hit.
  always_comb begin
    hi_ber_d  = status_q.hi_ber;
    ber_cnt_d = ber_cnt_q;
    timer_clr = 1'b0;
    timer_en  = 1'b1;
    if (!i_block_lock) begin
      hi_ber_d  = 1'b0;
      ber_cnt_d = '0;
      timer_clr = 1'b1;
    end else begin
      case (status_q.state)
        ST_INIT: begin
          hi_ber_d  = 1'b0;
          ber_cnt_d = '0;
          timer_clr = 1'b1;
          timer_en  = 1'b0;
        end
        ST_COUNT: begin
          if (hit) begin
            hi_ber_d  = 1'b1;
            ber_cnt_d = timer_done ? '0 : ber_cnt_q + BCNT_W'(1);
          end else if (timer_done) begin
            hi_ber_d  = 1'b0;
            ber_cnt_d = '0;
          end else if (bad_hdr) begin
            ber_cnt_d = ber_cnt_q + BCNT_W'(1);
          end
        end
        ST_HI_BER: begin
          hi_ber_d = 1'b1;
          if (timer_done) ber_cnt_d = '0;
        end
        default: begin
          hi_ber_d  = 1'b0;
          ber_cnt_d = '0;
          timer_clr = 1'b1;
        end
      endcase
    end
  end

  // Clear coincident with a new error leaves exactly that error counted.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      err_cnt_q <= '0;
    end else if (i_ber_count_clr) begin
      err_cnt_q <= CNT_WIDTH'(err_inc);
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_hi_ber    = status_q.hi_ber;
  assign o_ber_count = err_cnt_q;

endmodule

// File: doc/rx_ber_monitor.md
# rx_ber_monitor

Receive-side 10GBASE-R BER monitor implementing the IEEE 802.3 clause 49 BER state machine. It sits directly downstream of the receive gearbox/block-sync stage and consumes the recovered 2-bit sync header, its valid strobe and block lock. Over fixed 125 µs windows it counts invalid sync headers and asserts `o_hi_ber` when the count reaches threshold. It also keeps a saturating, host-clearable invalid-header counter.

## Interface
- `HDR_WIDTH`, 2, sync header width.
- `WINDOW_CYCLES`, 40283, window length in `i_clk` cycles (125 µs at 322.265625 MHz); must be ≥ 2.
- `BER_THRESHOLD`, 16, invalid headers per window that declare high BER; must be ≥ 1.
- `CNT_WIDTH`, 6, width of the saturating error counter.
- `i_clk`  in  1  sole clock.
- `i_reset_n`  in  1  reset; synchronous, active-low.
- `i_hdr`  in  HDR_WIDTH  sync header from block sync.
- `i_hdr_valid`  in  1  `i_hdr` is a new header this cycle.
- `i_block_lock`  in  1  block lock from the lock state machine.
- `i_ber_count_clr`  in  1  single-cycle clear of `o_ber_count`.
- `o_hi_ber`  out  1  high-BER indication to the decoder and host.
- `o_ber_count`  out  CNT_WIDTH  saturating count of invalid headers.

## Operation
- Valid header: 2'b01 (data) or 2'b10 (control). Invalid header: 2'b00 or 2'b11, counted only when `i_hdr_valid`=1.
- Internal state:
  - `timer`: $clog2(WINDOW_CYCLES) bits.
  - `ber_cnt`: $clog2(BER_THRESHOLD+1) bits.
- `timer_done` = (`timer` == WINDOW_CYCLES-1).
- `hit` = `i_hdr_valid` & invalid header & (`ber_cnt` == BER_THRESHOLD-1).
- States: ST_INIT, ST_COUNT, ST_HI_BER.
- **ST_INIT**
  - `timer`=0, `ber_cnt`=0, `o_hi_ber`=0.
  - Moves to ST_COUNT on the cycle after `i_block_lock`=1 is sampled.
- **ST_COUNT**
  - `timer` increments every cycle.
  - `ber_cnt` increments on each invalid valid header.
  - If `hit`: `o_hi_ber`←1.
    - If `timer_done` in the same cycle: `timer`←0, `ber_cnt`←0, stay in ST_COUNT.
    - Otherwise: go to ST_HI_BER.
  - Else if `timer_done`: `o_hi_ber`←0, `timer`←0, `ber_cnt`←0, stay in ST_COUNT.
- **ST_HI_BER**
  - `timer` keeps running; `ber_cnt` is frozen; `o_hi_ber` stays 1.
  - On `timer_done`: `timer`←0, `ber_cnt`←0, go to ST_COUNT. `o_hi_ber` stays 1 until a later window in ST_COUNT closes without `hit`.
- **Block lock loss**: `i_block_lock`=0 in any state forces ST_INIT on the next cycle with `o_hi_ber`←0. This has priority over every other transition.
- **`o_ber_count`**
  - Increments on each invalid valid header while `i_block_lock`=1, in any state.
  - Saturates at 2^CNT_WIDTH-1.
  - `i_ber_count_clr` sets it to 0. Clear coincident with an increment yields 1.
- Headers with `i_hdr_valid`=0 are ignored entirely.

## Timing
- Registered outputs; reset values: `o_hi_ber`=0, `o_ber_count`=0, state ST_INIT, `timer`=0, `ber_cnt`=0.
- Reset mid-window discards all state on the next edge.
- Latency is 1 cycle:
  - the header that causes `hit` sets `o_hi_ber` on the next edge;
  - the increment of `o_ber_count` is visible the cycle after the header.
- With lock asserted at cycle 0, the window spans the WINDOW_CYCLES cycles starting at cycle 1. A clean window first clears `o_hi_ber` at the edge ending cycle WINDOW_CYCLES.
- No backpressure; `i_hdr_valid` may be high every cycle or at any duty cycle.

## Structure
- Shared package `pcs_pkg` holds:
  - state enum `ber_state_t`;
  - constants `SYNC_DATA`=2'b01, `SYNC_CTRL`=2'b10;
  - default window/threshold constants.
- One natural sub-module: `ber_window_timer`, with clear, enable and `done` output, parameterised by WINDOW_CYCLES.

## Test plan
Bench uses WINDOW_CYCLES=64, BER_THRESHOLD=16, CNT_WIDTH=6.
- **Reset:** hold `i_reset_n`=0 with random headers → `o_hi_ber`=0, `o_ber_count`=0 throughout.
- **Clean link:** lock high, 500 cycles of alternating 2'b01/2'b10, valid every cycle → `o_hi_ber` stays 0, `o_ber_count` stays 0.
- **Threshold crossing:**
  - 16 headers of 2'b11 inside one window → `o_hi_ber`=1 one cycle after the 16th;
  - a following clean window → `o_hi_ber`=0 at that window's end;
  - 15 errors in a window → `o_hi_ber` never set.
- **Simultaneous hit and timer done:** 16th error on the last window cycle → `o_hi_ber`=1 and the next window starts immediately.
- **Lock loss:** drop `i_block_lock` while `o_hi_ber`=1 → `o_hi_ber`=0 next cycle. Reassert lock → new window begins one cycle later.
- **Counter saturation and clear:**
  - 70 invalid headers → `o_ber_count`=63;
  - `i_ber_count_clr` alone → 0;
  - `i_ber_count_clr` with an invalid header → 1.
